id_stage: RTL and testbench

Instruction decode / issue stage sitting directly upstream of the execute-stage ALU of the 8-bit CPU. Accepts instruction bytes from fetch over a valid/ready handshake, assembles two-byte LOADIMM instructions, and reads the 4×8 register file with write-through bypass from writeback. Stalls on register hazards via a per-register scoreboard, and presents registered `op`/`s1`/`s2`/`imm`/`rd` to the ALU over a valid/ready handshake.

---
 rtl/id_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_id_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode / issue stage in front of the 8-bit ALU.
// Collects one- or two-byte instructions from fetch and reads the 4x8 register
// file, bypassing writeback data in the same cycle. A per-register pending
// scoreboard blocks issue on RAW and WAW hazards. The stage then presents a
// registered issue slot to execute over a valid/ready handshake.
module id_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_valid,
  input  logic [7:0] if_instr,
  output logic       if_ready,
  output logic       ex_valid,
  input  logic       ex_ready,
  output logic [3:0] ex_op,
  output logic [7:0] ex_s1,
  output logic [7:0] ex_s2,
  output logic [7:0] ex_imm,
  output logic [1:0] ex_rd,
  output logic       ex_wen,
  input  logic       wb_en,
  input  logic [1:0] wb_rd,
  input  logic [7:0] wb_data
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_NAND    = 4'h3;
  localparam logic [3:0] OP_SHL     = 4'h4;
  localparam logic [3:0] OP_SHR     = 4'h5;
  localparam logic [3:0] OP_OUT     = 4'h6;
  localparam logic [3:0] OP_IN      = 4'h7;
  localparam logic [3:0] OP_MOV     = 4'h8;
  localparam logic [3:0] OP_STORE   = 4'hE;
  localparam logic [3:0] OP_LOADIMM = 4'hF;

  state_t      state;
  state_t      state_next;

  // Instruction byte and immediate held while the instruction waits to issue.
  logic [7:0]  ir_p0;
  logic [7:0]  imm_p0;

  logic [7:0]  regs [4];
  logic [3:0]  pend;

  logic [3:0]  ir_op;
  logic [1:0]  ir_ra;
  logic [1:0]  ir_rb;

  logic [3:0]  dec_op;
  logic        dec_rd_a;
  logic        dec_rd_b;
  logic        dec_wen;

  logic        fetch_acc;
  logic [3:0]  wb_clr;
  logic [3:0]  pend_eff;
  logic [3:0]  pend_set;
  logic        hazard;
  logic        slot_free;
  logic        issue;
  logic [7:0]  s1_byp;
  logic [7:0]  s2_byp;

  assign ir_op     = ir_p0[7:4];
  assign ir_ra     = ir_p0[3:2];
  assign ir_rb     = ir_p0[1:0];

  assign if_ready  = (state != S_ISSUE);
  assign fetch_acc = if_valid && if_ready;

  // Opcode decode: which ports are read, whether ra is written, and the op
  // code handed to the ALU (undefined opcodes collapse to a NOP).
  always_comb begin
    dec_op   = OP_NOP;
    dec_rd_a = 1'b0;
    dec_rd_b = 1'b0;
    dec_wen  = 1'b0;
    case (ir_op)
      OP_ADD, OP_SUB, OP_NAND: begin
        dec_op   = ir_op;
        dec_rd_a = 1'b1;
        dec_rd_b = 1'b1;
        dec_wen  = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        dec_op   = ir_op;
        dec_rd_a = 1'b1;
        dec_wen  = 1'b1;
      end
      OP_OUT: begin
        dec_op   = ir_op;
        dec_rd_a = 1'b1;
      end
      OP_IN: begin
        dec_op   = ir_op;
        dec_wen  = 1'b1;
      end
      OP_MOV: begin
        dec_op   = ir_op;
        dec_rd_b = 1'b1;
        dec_wen  = 1'b1;
      end
      OP_STORE: begin
        dec_op   = ir_op;
        dec_rd_a = 1'b1;
        dec_rd_b = 1'b1;
      end
      OP_LOADIMM: begin
        dec_op   = ir_op;
        dec_wen  = 1'b1;
      end
      default: begin
        dec_op   = OP_NOP;
      end
    endcase
  end

  // Hazard detection: a register being written back this cycle no longer
  // counts as pending, and its value is taken from the bypass below.
  always_comb begin
    wb_clr    = wb_en ? (4'b0001 << wb_rd) : 4'b0000;
    pend_eff  = pend & ~wb_clr;
    hazard    = (dec_rd_a && pend_eff[ir_ra]) ||
                (dec_rd_b && pend_eff[ir_rb]) ||
                (dec_wen  && pend_eff[ir_ra]);
    slot_free = !ex_valid || ex_ready;
    issue     = (state == S_ISSUE) && !hazard && slot_free;
    pend_set  = (issue && dec_wen) ? (4'b0001 << ir_ra) : 4'b0000;
  end

  // Write-through operand read: same-cycle writeback to a source wins over
  // the stored register value.
  always_comb begin
    s1_byp = regs[ir_ra];
    s2_byp = regs[ir_rb];
    if (wb_en && (wb_rd == ir_ra)) begin
      s1_byp = wb_data;
    end
    if (wb_en && (wb_rd == ir_rb)) begin
      s2_byp = wb_data;
    end
  end

  // FSM next state: fetch opcode byte, optionally the immediate, then issue.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (fetch_acc) begin
          state_next = (if_instr[7:4] == OP_LOADIMM) ? S_IMM : S_ISSUE;
        end
      end
      S_IMM: begin
        if (fetch_acc) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // FSM state register; reset discards any half-received LOADIMM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Latch the opcode byte in S_FETCH and the immediate byte in S_IMM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_p0  <= '0;
      imm_p0 <= '0;
    end else if (fetch_acc) begin
      if (state == S_IMM) begin
        imm_p0 <= if_instr;
      end else begin
        ir_p0  <= if_instr;
      end
    end
  end

  // Register file, written only by the writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Scoreboard: writeback clears, issue of a writer sets; set wins on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~wb_clr) | pend_set;
    end
  end

  // Issue slot: loads on issue, empties when consumed, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_s1    <= '0;
      ex_s2    <= '0;
      ex_imm   <= '0;
      ex_rd    <= '0;
      ex_wen   <= 1'b0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_op    <= dec_op;
      ex_s1    <= s1_byp;
      ex_s2    <= s2_byp;
      ex_imm   <= (ir_op == OP_LOADIMM) ? imm_p0 : 8'h00;
      ex_rd    <= ir_ra;
      ex_wen   <= dec_wen;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by a randomized stream.
// Expected issue records come from an architectural model of the program and
// are consumed by an independent monitor on each execute handshake.
module tb_id_stage;

  logic       clk;
  logic       rst_n;
  logic       if_valid;
  logic [7:0] if_instr;
  logic       if_ready;
  logic       ex_valid;
  logic       ex_ready;
  logic [3:0] ex_op;
  logic [7:0] ex_s1;
  logic [7:0] ex_s2;
  logic [7:0] ex_imm;
  logic [1:0] ex_rd;
  logic       ex_wen;
  logic       wb_en;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;

  id_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_ready (if_ready),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_op    (ex_op),
    .ex_s1    (ex_s1),
    .ex_s2    (ex_s2),
    .ex_imm   (ex_imm),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] imm;
    logic [1:0] rd;
    logic       wen;
    logic       c1;
    logic       c2;
  } exp_t;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
  } wb_t;

  exp_t       exp_q [$];
  wb_t        wb_order [$];
  wb_t        wb_rdy [$];
  logic [7:0] mregs [4];
  logic [7:0] bytes_q [$];
  exp_t       mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Architectural model: operands are the register values after every older
  // writer has written back; writers update the model with their result.
  task automatic push_instr(input logic [7:0] b, input logic [7:0] imm, input logic [7:0] res);
    exp_t       e;
    logic [3:0] opc;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       reads_a;
    logic       reads_b;
    logic       writes;
    logic       known;
    opc     = b[7:4];
    ra      = b[3:2];
    rb      = b[1:0];
    reads_a = opc inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE};
    reads_b = opc inside {4'h1, 4'h2, 4'h3, 4'h8, 4'hE};
    writes  = opc inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hF};
    known   = opc inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF};
    e.op    = known ? opc : 4'h0;
    e.s1    = mregs[ra];
    e.s2    = mregs[rb];
    e.imm   = (opc == 4'hF) ? imm : 8'h00;
    e.rd    = ra;
    e.wen   = writes;
    e.c1    = reads_a || writes;
    e.c2    = reads_b;
    exp_q.push_back(e);
    if (writes) mregs[ra] = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int   n;
    if_valid = 1'b1;
    if_instr = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = if_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if_valid = 1'b0;
    if_instr = 8'h00;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, required accept within 50 cycles", b);
    end
  endtask

  task automatic do_wb(input logic [1:0] r, input logic [7:0] d);
    wb_en   = 1'b1;
    wb_rd   = r;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  // Monitor: every consumed issue slot is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: got op 0x%0h, required no issue", ex_op);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_op",  32'(ex_op),  32'(mon_e.op));
        check("mon_rd",  32'(ex_rd),  32'(mon_e.rd));
        check("mon_wen", 32'(ex_wen), 32'(mon_e.wen));
        check("mon_imm", 32'(ex_imm), 32'(mon_e.imm));
        if (mon_e.c1) check("mon_s1", 32'(ex_s1), 32'(mon_e.s1));
        if (mon_e.c2) check("mon_s2", 32'(ex_s2), 32'(mon_e.s2));
      end
    end
  end

  initial begin
    int         pos;
    int         cyc;
    logic       acc;
    logic       cons;
    logic [7:0] b;
    logic [7:0] v;

    rst_n = 1'b0; if_valid = 1'b0; if_instr = 8'h00; ex_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 2'd0; wb_data = 8'h00;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_ex_op",    32'(ex_op),    32'h0);
    check("rst_ex_s1",    32'(ex_s1),    32'h0);
    check("rst_ex_s2",    32'(ex_s2),    32'h0);
    check("rst_ex_imm",   32'(ex_imm),   32'h0);
    check("rst_ex_rd",    32'(ex_rd),    32'h0);
    check("rst_ex_wen",   32'(ex_wen),   32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_if_ready", 32'(if_ready), 32'h1);

    // Reset in the middle of a LOADIMM; next byte decodes as a new opcode
    send(8'hF4);
    rst_n = 1'b0;
    #2;
    check("midrst_ex_valid", 32'(ex_valid), 32'h0);
    check("midrst_ex_op",    32'(ex_op),    32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_if_ready", 32'(if_ready), 32'h1);
    push_instr(8'h7C, 8'h00, 8'h07);
    send(8'h7C);
    tick();
    check("fresh_valid", 32'(ex_valid), 32'h1);
    check("fresh_op",    32'(ex_op),    32'h7);
    do_wb(2'd3, 8'h07);
    do_wb(2'd1, 8'h05); mregs[1] = 8'h05;
    do_wb(2'd2, 8'h03); mregs[2] = 8'h03;

    // Independent ops: ADD R1,R2 then SHL R3
    push_instr(8'h16, 8'h00, 8'h08);
    push_instr(8'h4C, 8'h00, 8'h0E);
    send(8'h16);
    tick();
    check("ind_add_valid", 32'(ex_valid), 32'h1);
    check("ind_add_op",    32'(ex_op),    32'h1);
    check("ind_add_s1",    32'(ex_s1),    32'h05);
    check("ind_add_s2",    32'(ex_s2),    32'h03);
    check("ind_add_rd",    32'(ex_rd),    32'h1);
    check("ind_add_wen",   32'(ex_wen),   32'h1);
    send(8'h4C);
    tick();
    check("ind_shl_op", 32'(ex_op), 32'h4);
    check("ind_shl_s1", 32'(ex_s1), 32'h07);
    do_wb(2'd1, 8'h08);
    do_wb(2'd3, 8'h0E);

    // RAW stall then bypass: LOADIMM R1,0x2A ; MOV R0,R1
    push_instr(8'hF4, 8'h2A, 8'h2A);
    push_instr(8'h81, 8'h00, 8'h2A);
    send(8'hF4);
    send(8'h2A);
    tick();
    check("li_op",  32'(ex_op),  32'hF);
    check("li_imm", 32'(ex_imm), 32'h2A);
    check("li_rd",  32'(ex_rd),  32'h1);
    send(8'h81);
    repeat (3) begin
      tick();
      check("raw_stall_valid",    32'(ex_valid), 32'h0);
      check("raw_stall_if_ready", 32'(if_ready), 32'h0);
    end
    wb_en = 1'b1; wb_rd = 2'd1; wb_data = 8'h2A;
    tick();
    wb_en = 1'b0;
    check("raw_mov_valid", 32'(ex_valid), 32'h1);
    check("raw_mov_op",    32'(ex_op),    32'h8);
    check("raw_mov_s2",    32'(ex_s2),    32'h2A);
    check("raw_mov_rd",    32'(ex_rd),    32'h0);
    do_wb(2'd0, 8'h2A);

    // Backpressure: slot holds while ex_ready is low
    ex_ready = 1'b0;
    push_instr(8'h16, 8'h00, 8'h2D);
    push_instr(8'h6C, 8'h00, 8'h00);
    send(8'h16);
    tick();
    send(8'h6C);
    repeat (5) begin
      tick();
      check("bp_valid",    32'(ex_valid), 32'h1);
      check("bp_op",       32'(ex_op),    32'h1);
      check("bp_s1",       32'(ex_s1),    32'h2A);
      check("bp_s2",       32'(ex_s2),    32'h03);
      check("bp_if_ready", 32'(if_ready), 32'h0);
    end
    ex_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(ex_valid), 32'h1);
    check("bp_next_op",    32'(ex_op),    32'h6);
    check("bp_next_s1",    32'(ex_s1),    32'h0E);
    do_wb(2'd1, 8'h2D);

    // Scoreboard collision: new writer to R2 issues as R2 is written back
    push_instr(8'h78, 8'h00, 8'h11);
    push_instr(8'h78, 8'h00, 8'h22);
    push_instr(8'h68, 8'h00, 8'h00);
    send(8'h78);
    tick();
    check("col_first_op", 32'(ex_op), 32'h7);
    send(8'h78);
    tick();
    check("col_waw_stall", 32'(ex_valid), 32'h0);
    wb_en = 1'b1; wb_rd = 2'd2; wb_data = 8'h11;
    tick();
    wb_en = 1'b0;
    check("col_issue_valid", 32'(ex_valid), 32'h1);
    check("col_issue_op",    32'(ex_op),    32'h7);
    send(8'h68);
    repeat (3) begin
      tick();
      check("col_out_stall", 32'(ex_valid), 32'h0);
    end
    wb_en = 1'b1; wb_rd = 2'd2; wb_data = 8'h22;
    tick();
    wb_en = 1'b0;
    check("col_out_valid", 32'(ex_valid), 32'h1);
    check("col_out_op",    32'(ex_op),    32'h6);
    check("col_out_s1",    32'(ex_s1),    32'h22);

    // Non-writers and undefined opcode leave the scoreboard alone
    push_instr(8'hE6, 8'h00, 8'h00);
    push_instr(8'h90, 8'h00, 8'h00);
    push_instr(8'h84, 8'h00, 8'h33);
    send(8'hE6);
    tick();
    check("st_op",  32'(ex_op),  32'hE);
    check("st_wen", 32'(ex_wen), 32'h0);
    send(8'h90);
    tick();
    check("nop_valid", 32'(ex_valid), 32'h1);
    check("nop_op",    32'(ex_op),    32'h0);
    check("nop_wen",   32'(ex_wen),   32'h0);
    send(8'h84);
    tick();
    check("after_nop_valid", 32'(ex_valid), 32'h1);
    check("after_nop_op",    32'(ex_op),    32'h8);
    do_wb(2'd1, 8'h33);

    // Randomized program with random backpressure and writeback delay
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF) begin
        v = 8'($urandom);
        push_instr(b, v, v);
        bytes_q.push_back(b);
        bytes_q.push_back(v);
      end else begin
        v = 8'($urandom);
        push_instr(b, 8'h00, v);
        bytes_q.push_back(b);
      end
      if (b[7:4] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hF})
        wb_order.push_back('{rd: b[3:2], val: v});
    end
    pos = 0;
    cyc = 0;
    while ((pos < bytes_q.size() || exp_q.size() > 0 || wb_order.size() > 0 || wb_rdy.size() > 0)
           && cyc < 20000) begin
      if_valid = (pos < bytes_q.size()) && ($urandom_range(0, 9) < 8);
      if_instr = (pos < bytes_q.size()) ? bytes_q[pos] : 8'h00;
      ex_ready = ($urandom_range(0, 9) < 7);
      if (wb_rdy.size() > 0 && $urandom_range(0, 9) < 6) begin
        wb_en   = 1'b1;
        wb_rd   = wb_rdy[0].rd;
        wb_data = wb_rdy[0].val;
      end else begin
        wb_en   = 1'b0;
      end
      @(negedge clk);
      acc  = if_valid && if_ready;
      cons = ex_valid && ex_ready && ex_wen;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) pos++;
      if (wb_en) void'(wb_rdy.pop_front());
      if (cons && wb_order.size() > 0) wb_rdy.push_back(wb_order.pop_front());
    end
    if_valid = 1'b0;
    wb_en    = 1'b0;
    ex_ready = 1'b1;
    if (cyc >= 20000) begin
      n_checks++;
      $display("FAIL random_timeout: %0d instructions outstanding, required 0 within 20000 cycles",
               exp_q.size());
    end
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
